// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level round-robin arbiter sharing one UART TX among byte-stream requesters
// Grant is held for a whole message; a one-entry buffer decouples requesters from the UART handshake.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [8*N_REQ-1:0]       i_req_data,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ-1:0]         i_req_last,
  input  logic [N_REQ-1:0]         i_req_break,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  output logic                     o_tx_break_en,
  input  logic                     i_tx_ready,
  output logic                     o_grant_vld,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYC);
  localparam logic [IDW-1:0] ID_LAST = IDW'(N_REQ - 1);
  localparam logic [IDW:0]   N_WIDE  = (IDW + 1)'(N_REQ);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e         state_q;
  logic [IDW-1:0] gid_q;
  logic [IDW-1:0] rr_q;
  logic [CW-1:0]  cnt_q;
  logic [7:0]     data_q;
  logic           brk_q;
  logic           valid_q;
  logic           timeout_q;

  logic [IDW-1:0] pick_d;
  logic           pick_vld_d;
  logic [IDW-1:0] rr_d;
  logic [IDW:0]   idx;
  logic [7:0]     g_data;
  logic           g_valid;
  logic           g_last;
  logic           g_break;
  logic           hs;

  assign g_valid = i_req_valid[gid_q];
  assign g_last  = i_req_last[gid_q];
  assign g_break = i_req_break[gid_q];
  assign hs      = (state_q == GRANT) && !valid_q && g_valid;
  assign rr_d    = (gid_q == ID_LAST) ? '0 : gid_q + 1'b1;

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gid_q == IDW'(i)) g_data = i_req_data[8*i +: 8];
    end
  end

  // Search rr_q, rr_q+1, ... with wrap; the first valid requester wins.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_d     = '0;
    idx        = '0;
    for (int j = 0; j < N_REQ; j++) begin
      idx = {1'b0, rr_q} + (IDW + 1)'(j);
      if (idx >= N_WIDE) idx = idx - N_WIDE;
      if (!pick_vld_d && i_req_valid[idx[IDW-1:0]]) begin
        pick_vld_d = 1'b1;
        pick_d     = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      o_req_ready[i] = (state_q == GRANT) && (gid_q == IDW'(i)) && !valid_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gid_q     <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      brk_q     <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (valid_q && i_tx_ready) begin
        valid_q <= 1'b0;
        brk_q   <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            state_q <= GRANT;
            gid_q   <= pick_d;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          // An accepted byte takes priority over an expiring timeout so no byte is lost.
          if (hs) begin
            valid_q <= 1'b1;
            data_q  <= g_data;
            brk_q   <= g_break;
            cnt_q   <= '0;
            if (g_last) begin
              state_q <= IDLE;
              rr_q    <= rr_d;
            end
          end else if (cnt_q == CNT_MAX) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
            rr_q      <= rr_d;
          end else if (!g_valid) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_data     = data_q;
  assign o_tx_valid    = valid_q;
  assign o_tx_break_en = brk_q;
  assign o_grant_vld   = (state_q == GRANT);
  assign o_grant_id    = gid_q;
  assign o_timeout     = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares one UART transmitter among N_REQ byte-stream requesters. Each requester sends a message: a byte sequence ending with a `last` byte. The arbiter locks the grant for the whole message, so messages never interleave on the serial line. It also forwards per-byte break requests and frees a stalled grant after a timeout. It sits between client FIFOs and the UART TX parallel interface (`i_data`, `i_data_valid`, `o_ready`, `i_break_en`).

## Interface
- N_REQ, default 4: number of requesters; legal range 2..16.
- TIMEOUT_CYC, default 1024: idle clk cycles allowed mid-message before the grant is revoked; legal range ≥ 1.
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- i_req_data  in  8*N_REQ  byte from requester i, at bits [8i+7:8i].
- i_req_valid  in  N_REQ  byte valid, per requester.
- i_req_last  in  N_REQ  final byte of the message, per requester.
- i_req_break  in  N_REQ  send this byte as a break frame, per requester.
- o_req_ready  out  N_REQ  byte accepted this cycle where valid & ready.
- o_tx_data  out  8  byte to the UART TX.
- o_tx_valid  out  1  o_tx_data is valid.
- o_tx_break_en  out  1  break enable, aligned with o_tx_data.
- i_tx_ready  in  1  ready from the UART TX.
- o_grant_vld  out  1  a requester currently holds the grant.
- o_grant_id  out  $clog2(N_REQ)  index of the granted requester.
- o_timeout  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States:
  - IDLE: no grant held.
  - GRANT: one requester owns the link.
- Output buffer: one entry, holding obuf_data, obuf_brk and o_tx_valid.
  - Loads when the granted requester handshakes (`o_req_ready[g] & i_req_valid[g]`).
  - Clears when `o_tx_valid & i_tx_ready`.
  - Load and clear never coincide, because ready requires the buffer to be empty.
- `o_req_ready[i]` = (state==GRANT) & (o_grant_id==i) & ~o_tx_valid. This is combinational from registers only; no input-to-output path.
- IDLE, when any `i_req_valid` is high:
  - Pick the first valid index searching rr_ptr, rr_ptr+1, … and wrapping modulo N_REQ.
  - Register it into o_grant_id, set o_grant_vld=1, go to GRANT.
- GRANT, on a handshake with `i_req_last[g]`=1: go to IDLE, clear o_grant_vld, set rr_ptr ← (g+1) mod N_REQ. The last byte still drains from the buffer.
- Arbitration in IDLE may proceed while the buffer is full; the new owner simply waits for an empty buffer.
- Timeout counter:
  - Cleared on grant and on every accepted byte.
  - Increments on each GRANT cycle where `i_req_valid[g]`=0; cycles stalled by a full buffer do not count.
  - At TIMEOUT_CYC: pulse o_timeout, go to IDLE, set rr_ptr ← (g+1) mod N_REQ.
- Break: i_req_break is captured with the byte into obuf_brk and presented as o_tx_break_en for as long as o_tx_valid is high. The data byte is forwarded unchanged; the UART zeroes it.
- Valid, last and break of non-granted requesters are ignored.
- Counter width is $clog2(TIMEOUT_CYC+1); it never wraps.

## Timing
- Reset value of all outputs and internal registers is 0: o_tx_data, o_tx_valid, o_tx_break_en, o_req_ready, o_grant_vld, o_grant_id, o_timeout, rr_ptr, state = IDLE.
- Asynchronous reset mid-message drops the buffered byte and the grant immediately. No partial state survives.
- Request to grant: valid seen in IDLE at edge k gives o_grant_vld=1 after edge k. o_req_ready rises in the same cycle if the buffer is empty.
- Byte path latency: handshake at edge k gives o_tx_valid=1 after edge k. With i_tx_ready=1 the byte is consumed at edge k+1, and o_req_ready is high again after edge k+1.
- Peak throughput is 1 byte per 2 clk cycles, far above the UART byte rate.
- Grant turnaround: last byte at edge k, IDLE after k, next grant after k+1. There is one dead cycle between messages.
- Timeout: o_timeout is high for exactly one cycle, the cycle after the counter reaches TIMEOUT_CYC. o_grant_vld falls at the same edge.
- o_tx_valid, once high, stays high with stable o_tx_data and o_tx_break_en until i_tx_ready.

## Test plan
- Single requester:
  - Stimulus: req0 sends 0x55, 0xA3 with last on 0xA3; i_tx_ready pulses once every 10 cycles.
  - Required: o_tx_data sequence 0x55 then 0xA3; o_grant_vld falls one cycle after the 0xA3 handshake; rr_ptr=1.
- Round-robin:
  - Stimulus: all 4 requesters continuously valid, 1-byte messages (last=1).
  - Required: grant order 0,1,2,3,0,…; each o_tx_data equals the owner's byte.
- Message locking:
  - Stimulus: req2 sends a 3-byte message while req1 is valid throughout.
  - Required: all 3 req2 bytes are output contiguously; req1 is granted next; o_req_ready[1]=0 during req2's message.
- Timeout:
  - Stimulus: TIMEOUT_CYC=8; req3 sends 1 byte without last, then deasserts valid.
  - Required: o_timeout pulses 9 cycles after the last accepted byte (8 counted idle cycles, then the pulse cycle); grant released; rr_ptr=0.
- Break and backpressure:
  - Stimulus: req1 byte 0x7E with break=1; i_tx_ready held low for 20 cycles.
  - Required: o_tx_valid=1, o_tx_data=0x7E, o_tx_break_en=1, all stable for 20 cycles; consumed on the first ready.
- Reset mid-message:
  - Stimulus: assert rstn=0 while o_tx_valid=1.
  - Required: all outputs 0 immediately; after release, arbitration starts from requester 0.
